// File: rtl/alarm_sched_if.sv
// alarm_sched_if: scheduler inputs from the time/alarm datapath
// and buzzer/status outputs back to the display logic.
interface alarm_sched_if;
    logic       sectick;
    logic       match;
    logic       alarmon;
    logic [2:0] day;
    logic [6:0] daymask;
    logic       snooze;
    logic       stop;
    logic       buzz;
    logic       snoozing;
    logic [1:0] snzleft;

    modport master (
        output sectick, match, alarmon, day, daymask,
        output snooze, stop,
        input  buzz, snoozing, snzleft
    );

    modport slave (
        input  sectick, match, alarmon, day, daymask,
        input  snooze, stop,
        output buzz, snoozing, snzleft
    );
endinterface

// File: rtl/alarm_sched.sv
// alarm_sched: ring / snooze / auto-off sequencer for the alarm clock.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sched #(
    parameter int RING_S   = 60,
    parameter int SNOOZE_S = 540,
    parameter int MAX_SNZ  = 3
) (
    input  logic          pulse,
    input  logic          reset,
    alarm_sched_if.slave  ifc
);
    localparam int RW = (RING_S > 1) ? $clog2(RING_S) : 1;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_S + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    logic [SW-1:0] snz_q, snz_d;
    logic [1:0]    left_q, left_d;
`else
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic          match_q;
    logic [RW-1:0] ring_q, ring_d;
    logic [7:0]    dm8;
    logic          mrise;
    logic          arm;

    assign dm8   = {1'b0, ifc.daymask};
    assign mrise = ifc.match & ~match_q;
    assign arm   = mrise & ifc.alarmon
                 & (ifc.day != 3'd7) & dm8[ifc.day];

    // match_q follows Match even in reset so a level held
    // across reset or disable is never seen as a fresh rise
    always_ff @(posedge pulse) begin
        match_q <= ifc.match;
        if (reset) begin
            state_q <= IDLE;
            ring_q  <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_q   <= '0;
            left_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
`ifdef ALARM_SNOOZE_EN
            snz_q   <= snz_d;
            left_q  <= left_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
        snz_d   = snz_q;
        left_d  = left_q;
`endif
        if (!ifc.alarmon || ifc.stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = RINGING;
`ifdef ALARM_SNOOZE_EN
                        left_d  = 2'(MAX_SNZ);
`endif
                    end
                end
                RINGING: begin
`ifdef ALARM_SNOOZE_EN
                    if (ifc.snooze && left_q != 2'd0) begin
                        state_d = SNOOZE;
                        snz_d   = SW'(SNOOZE_S);
                        left_d  = left_q - 2'd1;
                    end else
`endif
                    if (ifc.sectick) begin
                        if (ring_q == RW'(RING_S - 1))
                            state_d = IDLE;
                        else
                            ring_d = ring_q + 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (ifc.sectick) begin
                        if (snz_q == SW'(1))
                            state_d = RINGING;
                        else if (snz_q != '0)
                            snz_d = snz_q - 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        if (state_d != RINGING)
            ring_d = '0;
`ifdef ALARM_SNOOZE_EN
        if (state_d != SNOOZE)
            snz_d = '0;
        if (state_d == IDLE)
            left_d = '0;
`endif
    end

    assign ifc.buzz = (state_q == RINGING);

`ifdef ALARM_SNOOZE_EN
    assign ifc.snoozing = (state_q == SNOOZE);
    assign ifc.snzleft  = left_q;
`else
    logic unused_ok;
    assign unused_ok    = ^{ifc.snooze, SNOOZE_S[0], MAX_SNZ[0]};
    assign ifc.snoozing = 1'b0;
    assign ifc.snzleft  = 2'd0;
`endif
endmodule
